fpadd_rr_scheduler: RTL and testbench
=====================================

Name: fpadd_rr_scheduler

Overview:
- Shares one fixed-latency, non-stallable FP32 adder (valid-less: A/B in, result out LATENCY cycles later) among N_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle and tracks each operation's owner through a tag pipeline.
- Holds each result in a per-requester buffer until that requester takes it.
- Sits between the FP32 client ports and the adder datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LATENCY, 2, cycles from add_a/add_b driven to add_result valid (adder's input register plus output register).
- TAG_W, $clog2(N_REQ), derived owner-tag width; not overridden.

Ports:
- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  per-requester accept; a handshake occurs when valid and ready are both high.
- req_a  in  32*N_REQ  operand A, slice i belongs to requester i.
- req_b  in  32*N_REQ  operand B, slice i belongs to requester i.
- resp_valid  out  N_REQ  result available.
- resp_ready  in  N_REQ  requester takes the result.
- resp_data  out  32*N_REQ  FP32 sum, slice i belongs to requester i.
- add_a  out  32  adder operand A.
- add_b  out  32  adder operand B.
- add_result  in  32  adder sum.
- inflight  out  TAG_W+1  number of operations issued and not yet captured.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Per-requester FSM, slot state for requester i:
  - IDLE -> BUSY on request handshake.
  - BUSY -> DONE when its tag exits the pipeline.
  - DONE -> IDLE on resp_valid[i] && resp_ready[i].
  - At most one outstanding operation per requester, so the non-stallable adder never overflows a buffer.
- Eligibility: requester i is eligible when req_valid[i] && state_i==IDLE.
- Arbitration:
  - Round-robin among eligible requesters. Search starts at last_grant+1 and wraps modulo N_REQ.
  - req_ready[i] = grant[i]. This is combinational from req_valid; at most one bit is high per cycle.
  - last_grant updates only on a grant.
- Issue, grant in cycle t:
  - add_a/add_b carry the granted requester's operands, combinationally, in cycle t.
  - add_a/add_b are 32'h0 when there is no grant.
  - The tag pipe (valid bit + TAG_W tag, LATENCY stages) is loaded at the end of cycle t.
- Capture:
  - In cycle t+LATENCY the last tag stage is valid. At that clock edge, add_result is written into resp_data slice [tag] and that slot goes to DONE.
  - resp_valid[tag] is high from cycle t+LATENCY+1.
  - Minimum request-to-response latency is LATENCY+1 cycles.
- Hold: while resp_valid[i] is high and resp_ready[i] is low, resp_data slice i stays stable.
- Simultaneous events:
  - A response handshake and a new req_valid on the same requester in the same cycle: req_ready stays 0 that cycle, and the request becomes eligible the next cycle.
  - Captures for different requesters never collide, since the pipeline carries one tag per stage.
- inflight: +1 on grant, -1 on capture. Both in the same cycle leaves it unchanged.
- Reset values, applied at the clock edge while reset is high:
  - All slots IDLE and the tag pipe cleared; in-flight results are discarded.
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - resp_valid = 0, resp_data = 0, inflight = 0.
  - req_ready is forced to 0 and add_a/add_b to 0 while reset is high.
- Adder result format, including zero/sign handling, is the adder's responsibility; data passes through unmodified.

Decomposition:
- Package fpadd_sched_pkg:
  - FP32_W=32.
  - Slot state enum {IDLE, BUSY, DONE}.
  - Default LATENCY.
  - Tag-pipe entry struct {valid, tag}.
- Sub-module rr_arbiter (params N), natural to split out:
  - Inputs: eligible vector, last_grant.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; the last_grant register stays in the parent.

Test Plan (all tests with LATENCY=2, N_REQ=4):
- Single request: req0 valid at cycle 0 with a=0x3F800000, b=0x40000000 -> req_ready[0]=1 and add_a=0x3F800000 in cycle 0; resp_valid[0]=1 at cycle 3 with resp_data[31:0]=0x40400000; inflight goes 1 then 0.
- Four requests at once: all four req_valid at cycle 0 with distinct operands (e.g. 1.5+2.5 -> 0x40800000) -> grants 0,1,2,3 in cycles 0..3, one per cycle; resp_valid in cycles 3,4,5,6, each result on its own slice.
- Backpressure: resp_ready[1]=0 for 10 cycles -> resp_valid[1] and its data held constant; req_ready[1]=0 despite req_valid[1]; requesters 0, 2 and 3 keep issuing and completing.
- Fairness: req0 and req2 continuously valid, every resp_ready=1 -> grants strictly alternate 0,2,0,2 and no requester is ever skipped while eligible.
- Same-cycle response and request: in the cycle req0 takes its result it also asserts a new req_valid -> req_ready[0]=0 that cycle and =1 the next cycle, provided no other requester is eligible.
- Reset mid-flight: reset high for 1 cycle at cycle 1 after a cycle-0 grant -> no resp_valid ever appears for that operation; inflight=0; the first post-reset grant with all valid goes to req0.

Source files
------------

// File: rtl/fpadd_sched_pkg.sv
// Shared types and constants for the FP32 adder round-robin scheduler.
package fpadd_sched_pkg;

  localparam int unsigned FP32_W          = 32;
  localparam int unsigned DEFAULT_LATENCY = 2;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned MAX_TAG_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } slot_state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/fpadd_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter.
// Ports: eligible (request vector), last_grant (previous winner);
//        grant (one-hot), grant_idx (winner index), any_grant.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    // Search starts one past the previous winner and wraps.
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDX_W'((32'(last_grant) + k) % N);
      if (!any_grant && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpadd_rr_scheduler.sv
// Shares one fixed-latency FP32 adder among N_REQ requesters.
// Ports: req_* (operand requests), resp_* (buffered results),
//        add_a/add_b/add_result (adder datapath), inflight (issued, not captured).
module fpadd_rr_scheduler
  import fpadd_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = DEFAULT_LATENCY,
  parameter int unsigned TAG_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [FP32_W*N_REQ-1:0]   req_a,
  input  logic [FP32_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]          resp_valid,
  input  logic [N_REQ-1:0]          resp_ready,
  output logic [FP32_W*N_REQ-1:0]   resp_data,
  output logic [FP32_W-1:0]         add_a,
  output logic [FP32_W-1:0]         add_b,
  input  logic [FP32_W-1:0]         add_result,
  output logic [TAG_W:0]            inflight
);

  slot_state_t              slot_q [N_REQ];
  slot_state_t              slot_d [N_REQ];
  tag_entry_t               pipe_q [LATENCY];
  logic [TAG_W-1:0]         last_grant_q;
  logic [N_REQ-1:0]         eligible;
  logic [N_REQ-1:0]         grant;
  logic [TAG_W-1:0]         grant_idx;
  logic                     any_grant;
  logic [N_REQ-1:0]         capture;
  logic [FP32_W*N_REQ-1:0]  resp_data_q;
  logic [TAG_W:0]           inflight_q;

  // Gating with reset keeps req_ready and the adder operands at zero during reset.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (slot_q[i] == IDLE) && !reset;
    end
  end

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (TAG_W)
  ) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        add_a = req_a[i*FP32_W +: FP32_W];
        add_b = req_b[i*FP32_W +: FP32_W];
      end
    end
  end

  always_comb begin
    capture = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      capture[i] = pipe_q[LATENCY-1].valid && (pipe_q[LATENCY-1].tag == MAX_TAG_W'(i));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slot_d[i] = slot_q[i];
      unique case (slot_q[i])
        IDLE:    if (grant[i])      slot_d[i] = BUSY;
        BUSY:    if (capture[i])    slot_d[i] = DONE;
        DONE:    if (resp_ready[i]) slot_d[i] = IDLE;
        default: slot_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      resp_valid[i] = (slot_q[i] == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REQ; i++) slot_q[i] <= IDLE;
      for (int unsigned s = 0; s < LATENCY; s++) pipe_q[s] <= '0;
      last_grant_q <= TAG_W'(N_REQ - 1);
      resp_data_q  <= '0;
      inflight_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) slot_q[i] <= slot_d[i];
      pipe_q[0] <= '{valid: any_grant, tag: MAX_TAG_W'(grant_idx)};
      for (int unsigned s = 1; s < LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
      if (any_grant) last_grant_q <= grant_idx;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (capture[i]) resp_data_q[i*FP32_W +: FP32_W] <= add_result;
      end
      inflight_q <= inflight_q + (TAG_W+1)'(any_grant) - (TAG_W+1)'(|capture);
    end
  end

  assign req_ready = grant;
  assign resp_data = resp_data_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_fpadd_rr_scheduler.sv
// Self-checking bench for fpadd_rr_scheduler with a behavioural FP32 adder.
module tb_fpadd_rr_scheduler;

  localparam int N = 4;
  localparam int L = 2;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [32*N-1:0]   resp_data;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic [31:0]       add_result;
  logic [2:0]        inflight;

  fpadd_rr_scheduler #(
    .N_REQ   (N),
    .LATENCY (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .inflight   (inflight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic real fp32_to_real(logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp32(real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'h0;
    e = int'(d[62:52]) - 896;
    if (e <= 0)   return {d[63], 31'b0};
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  // Two-stage adder: input register then output register.
  logic [31:0] a_r, b_r, sum_r;
  always_ff @(posedge clk) begin
    a_r   <= add_a;
    b_r   <= add_b;
    sum_r <= fadd(a_r, b_r);
  end
  assign add_result = sum_r;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: each requester holds at most one op, stamped with its grant cycle.
  bit          pend  [N];
  int          gcyc  [N];
  logic [31:0] edata [N];
  int          ptr;
  int          cyc;
  int          exp_g;
  logic [N-1:0] ev;

  task automatic model_clear();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    ptr = N - 1;
  endtask

  task automatic sample_check();
    logic [N-1:0] erdy;
    logic [31:0]  ea, eb;
    int           infl;
    int           j;
    #3;
    exp_g = -1;
    if (!reset) begin
      for (int k = 1; k <= N; k++) begin
        j = (ptr + k) % N;
        if (exp_g < 0 && req_valid[j] && !pend[j]) exp_g = j;
      end
    end
    erdy = '0;
    ea   = '0;
    eb   = '0;
    if (exp_g >= 0) begin
      erdy[exp_g] = 1'b1;
      ea = req_a[exp_g*32 +: 32];
      eb = req_b[exp_g*32 +: 32];
    end
    infl = 0;
    ev   = '0;
    for (int i = 0; i < N; i++) begin
      ev[i] = pend[i] && (cyc >= gcyc[i] + L + 1);
      if (pend[i] && cyc > gcyc[i] && cyc <= gcyc[i] + L) infl++;
    end
    check("req_ready", 32'(req_ready), 32'(erdy));
    check("add_a", add_a, ea);
    check("add_b", add_b, eb);
    check("resp_valid", 32'(resp_valid), 32'(ev));
    check("inflight", 32'(inflight), 32'(infl));
    for (int i = 0; i < N; i++) begin
      if (ev[i]) check("resp_data", resp_data[i*32 +: 32], edata[i]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ev[i] && resp_ready[i]) pend[i] = 1'b0;
      end
      if (exp_g >= 0) begin
        pend[exp_g]  = 1'b1;
        gcyc[exp_g]  = cyc;
        edata[exp_g] = fadd(req_a[exp_g*32 +: 32], req_b[exp_g*32 +: 32]);
        ptr          = exp_g;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_ops(int i, logic [31:0] a, logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic run(int n);
    for (int c = 0; c < n; c++) begin
      sample_check();
      advance();
    end
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = '1;
    run(6);
  endtask

  initial begin
    int          held;
    int          others;
    int          last;
    int          obs;
    int          ngr;
    logic [31:0] bp_data;

    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    req_a      = '0;
    req_b      = '0;
    bp_data    = '0;
    cyc        = 0;
    exp_g      = -1;
    for (int i = 0; i < N; i++) begin
      gcyc[i]  = 0;
      edata[i] = '0;
    end
    model_clear();
    @(posedge clk);
    #1;
    sample_check();
    check("rst_resp_data", 32'(|resp_data), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_inflight", 32'(inflight), 32'h0);
    advance();
    reset = 1'b0;

    // All four at once straight out of reset.
    set_ops(0, 32'h3FC00000, 32'h40200000);
    for (int i = 1; i < N; i++) set_ops(i, rand_fp(), rand_fp());
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      sample_check();
      if (c < 4) check("q_grant", 32'(req_ready), 32'(1 << c));
      if (c >= 3 && c <= 6) check("q_resp", 32'(resp_valid), 32'(1 << (c - 3)));
      if (c == 3) check("q_sum0", resp_data[31:0], 32'h40800000);
      advance();
      if (exp_g >= 0) req_valid[exp_g] = 1'b0;
    end

    // Single request.
    drain();
    set_ops(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    sample_check();
    check("s_ready", 32'(req_ready[0]), 32'h1);
    check("s_add_a", add_a, 32'h3F800000);
    advance();
    req_valid = '0;
    sample_check();
    check("s_infl1", 32'(inflight), 32'h1);
    advance();
    sample_check();
    advance();
    sample_check();
    check("s_rvalid", 32'(resp_valid[0]), 32'h1);
    check("s_rdata", resp_data[31:0], 32'h40400000);
    check("s_infl0", 32'(inflight), 32'h0);
    advance();

    // Backpressure on requester 1.
    drain();
    for (int i = 0; i < N; i++) set_ops(i, rand_fp(), rand_fp());
    resp_ready = 4'b1101;
    req_valid  = '1;
    held   = 0;
    others = 0;
    for (int c = 0; c < 14; c++) begin
      sample_check();
      if (ev[1]) begin
        check("bp_ready1", 32'(req_ready[1]), 32'h0);
        if (held != 0) check("bp_hold", resp_data[63:32], bp_data);
        else begin
          bp_data = resp_data[63:32];
          held    = 1;
        end
      end
      if (exp_g == 0 || exp_g == 2 || exp_g == 3) others++;
      advance();
      if (exp_g >= 0) set_ops(exp_g, rand_fp(), rand_fp());
    end
    check("bp_seen", 32'(held), 32'h1);
    check("bp_others", 32'(others >= 6), 32'h1);

    // Fairness between requesters 0 and 2.
    drain();
    req_valid = 4'b0101;
    last = -1;
    ngr  = 0;
    for (int c = 0; c < 24; c++) begin
      sample_check();
      obs = req_ready[0] ? 0 : (req_ready[2] ? 2 : -1);
      if (obs >= 0) begin
        if (last >= 0) check("fair_alt", 32'(obs), 32'(last == 0 ? 2 : 0));
        last = obs;
        ngr++;
      end
      advance();
      if (exp_g >= 0) set_ops(exp_g, rand_fp(), rand_fp());
    end
    check("fair_count", 32'(ngr >= 8), 32'h1);

    // Response handshake and new request in the same cycle.
    drain();
    req_valid = 4'b0001;
    sample_check();
    advance();
    req_valid = '0;
    run(2);
    req_valid = 4'b0001;
    sample_check();
    check("sc_rvalid", 32'(resp_valid[0]), 32'h1);
    check("sc_ready0", 32'(req_ready[0]), 32'h0);
    advance();
    sample_check();
    check("sc_ready1", 32'(req_ready[0]), 32'h1);
    advance();
    req_valid = '0;

    // Reset while an operation is in flight.
    drain();
    req_valid = 4'b0001;
    sample_check();
    check("rm_grant", 32'(req_ready), 32'h1);
    advance();
    req_valid = '1;
    reset     = 1'b1;
    sample_check();
    check("rm_rst_ready", 32'(req_ready), 32'h0);
    check("rm_rst_add_a", add_a, 32'h0);
    advance();
    reset     = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      sample_check();
      check("rm_no_resp", 32'(resp_valid), 32'h0);
      check("rm_infl", 32'(inflight), 32'h0);
      advance();
    end
    req_valid = '1;
    sample_check();
    check("rm_first", 32'(req_ready), 32'h1);
    advance();
    if (exp_g >= 0) req_valid[exp_g] = 1'b0;

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          set_ops(i, rand_fp(), rand_fp());
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = N'($urandom);
      sample_check();
      advance();
      if (exp_g >= 0) req_valid[exp_g] = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
